// File: rtl/iq_upconv_pkg.sv
// Shared types, slot constants and the slot selection function for the
// quadrature upconverter.
package iq_upconv_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_I  = 2'd0;
    localparam phase_t PH_Q  = 2'd1;
    localparam phase_t PH_NI = 2'd2;
    localparam phase_t PH_NQ = 2'd3;

    // Carrier cos/sin at fs/4 are +1,0,-1,0 and 0,+1,0,-1, so each slot passes
    // one channel, possibly inverted; the lower sideband flips the Q sign.
    function automatic logic slot_bit(input phase_t phase, input logic i,
                                      input logic q, input logic lsb);
        logic b;
        b = 1'b0;
        case (phase)
            PH_I:    b = i;
            PH_Q:    b = lsb ? ~q : q;
            PH_NI:   b = ~i;
            default: b = lsb ? q : ~q;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/iq_upconverter_phase_counter.sv
// Free-running 2-bit carrier phase counter with a frame_end flag on the
// last slot of each frame.
module iq_phase_counter
    import iq_upconv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] phase_o,
    output logic       frame_end_o
);

    phase_t phase_q;
    phase_t phase_d;

    assign phase_d     = phase_q + 2'd1;
    assign phase_o     = phase_q;
    assign frame_end_o = (phase_q == PH_NQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_I;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/iq_upconverter.sv
// 1-bit I/Q upconverter onto an fs/4 carrier. Optional baseband I passthrough
// for DAC debug is enabled by defining IQ_UPCONV_BYPASS_EN.
module iq_upconverter
    import iq_upconv_pkg::*;
#(
    parameter bit LSB_SIDEBAND = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_i,
    input  logic data_q,
`ifdef IQ_UPCONV_BYPASS_EN
    input  logic bypass,
`endif
    output logic data_out
);

    logic [1:0] phase;
    logic       frame_end;

    logic i_h_q, i_h_d;
    logic q_h_q, q_h_d;
    logic out_q, out_d;

    iq_phase_counter u_phase (
        .clk         (clk),
        .rst_n       (rst_n),
        .phase_o     (phase),
        .frame_end_o (frame_end)
    );

    // Inputs are only looked at on the last slot of a frame.
    assign i_h_d = frame_end ? data_i : i_h_q;
    assign q_h_d = frame_end ? data_q : q_h_q;

    // Output uses the hold values from before this edge's load.
    always_comb begin
        out_d = slot_bit(phase, i_h_q, q_h_q, LSB_SIDEBAND);
`ifdef IQ_UPCONV_BYPASS_EN
        if (bypass) begin
            out_d = i_h_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_h_q <= 1'b0;
            q_h_q <= 1'b0;
            out_q <= 1'b0;
        end else begin
            i_h_q <= i_h_d;
            q_h_q <= q_h_d;
            out_q <= out_d;
        end
    end

    assign data_out = out_q;

endmodule

// File: tb/tb_iq_upconverter.sv
// Directed bench for iq_upconverter: upper and lower sideband instances share
// the same stimulus; expected slot patterns are written out per frame.
module tb_iq_upconverter;

    logic clk;
    logic rst_n;
    logic data_i;
    logic data_q;
    logic bypass;
    logic out_u;
    logic out_l;

    int n_checks;
    int n_errors;

    iq_upconverter #(.LSB_SIDEBAND(1'b0)) dut_usb (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .data_q   (data_q),
`ifdef IQ_UPCONV_BYPASS_EN
        .bypass   (bypass),
`endif
        .data_out (out_u)
    );

    iq_upconverter #(.LSB_SIDEBAND(1'b1)) dut_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .data_q   (data_q),
`ifdef IQ_UPCONV_BYPASS_EN
        .bypass   (bypass),
`endif
        .data_out (out_l)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One frame starting just after a falling edge. di/dq give the inputs per
    // slot (MSB = slot 0); eu/el are the expected outputs per slot.
    task automatic run_frame(input string tag, input logic [3:0] di, input logic [3:0] dq,
                             input logic [3:0] eu, input logic [3:0] el);
        for (int k = 0; k < 4; k++) begin
            data_i = di[3-k];
            data_q = dq[3-k];
            @(posedge clk);
            #1;
            check_bit($sformatf("%s usb slot%0d", tag, k), out_u, eu[3-k]);
            check_bit($sformatf("%s lsb slot%0d", tag, k), out_l, el[3-k]);
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        data_i = 1'b1;
        data_q = 1'b1;
        bypass = 1'b0;

        // reset held for 3 cycles: output stays 0
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_bit("reset usb", out_u, 1'b0);
            check_bit("reset lsb", out_l, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // first frame from zero holds; load I=1, Q=0 at its end
        run_frame("first", 4'b1111, 4'b0000, 4'b0011, 4'b0110);
        run_frame("static1", 4'b1111, 4'b0000, 4'b1001, 4'b1100);
        // toggles off the phase-3 edge must be ignored
        run_frame("ignore_a", 4'b0101, 4'b1110, 4'b1001, 4'b1100);
        // load I=0, Q=1 only at the phase-3 edge
        run_frame("ignore_b", 4'b1110, 4'b0001, 4'b1001, 4'b1100);
        run_frame("i0q1", 4'b0001, 4'b0001, 4'b0110, 4'b0011);
        run_frame("i1q1", 4'b0000, 4'b0000, 4'b1100, 4'b1001);
        run_frame("i0q0", 4'b0001, 4'b0001, 4'b0011, 4'b0110);

        // mid-frame reset with holds I=1, Q=1: slots 0,1 then abort at phase 2
        for (int k = 0; k < 2; k++) begin
            data_i = 1'b1;
            data_q = 1'b1;
            @(posedge clk);
            #1;
            check_bit($sformatf("pre_abort usb slot%0d", k), out_u, 1'b1);
            check_bit($sformatf("pre_abort lsb slot%0d", k), out_l, k == 0 ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_bit("async reset usb", out_u, 1'b0);
        check_bit("async reset lsb", out_l, 1'b0);
        @(posedge clk);
        #1;
        check_bit("reset hold usb", out_u, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("restart", 4'b0000, 4'b0000, 4'b0011, 4'b0110);

`ifdef IQ_UPCONV_BYPASS_EN
        bypass = 1'b1;
        run_frame("bypass_load", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        run_frame("bypass_on", 4'b1111, 4'b0000, 4'b1111, 4'b1111);
        bypass = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global time limit
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, limit %0d ns", 100000);
        $fatal(1);
    end

endmodule
